// File: rtl/adder_result_checker_if.sv
// Handshake bundle carrying one adder transaction (operands plus adder-under-test outputs)
// from a stimulus source (master) to the result checker (slave).
interface adder_result_checker_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH:0]   S;
    logic [WIDTH-1:0] testP;
    logic [WIDTH-1:0] testG;

    modport master (
        output in_valid, A, B, Cin, S, testP, testG,
        input  in_ready
    );

    modport slave (
        input  in_valid, A, B, Cin, S, testP, testG,
        output in_ready
    );
endinterface

// File: rtl/adder_result_checker.sv
// Bit-serial golden-sum checker for a WIDTH-bit adder, CHUNK bits per cycle, with saturating counters.
// Define ADDER_CHECK_PG_EN to also check the propagate/generate vectors.
module adder_result_checker #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_checker_if.slave bus,
    output logic                 res_valid,
    output logic                 res_pass,
    output logic [WIDTH:0]       sum_err_mask,
    output logic                 pg_err,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("adder_result_checker: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, mask_sh;
    logic             s_msb, carry, mask_msb, pg_acc;
    logic [IDX_W-1:0] k;
    logic [CHUNK:0]   ref_sum;
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_pg_bad;

`ifdef ADDER_CHECK_PG_EN
    logic [WIDTH-1:0] p_sh, g_sh;
`else
    logic unused_pg;
    assign unused_pg = ^{bus.testP, bus.testG};
`endif

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // Operands are shifted right each CHECK cycle so the current chunk always sits in the low bits.
    always_comb begin
        ref_sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        chunk_diff   = ref_sum[CHUNK-1:0] ^ s_sh[CHUNK-1:0];
        chunk_pg_bad = 1'b0;
`ifdef ADDER_CHECK_PG_EN
        chunk_pg_bad = ((a_sh[CHUNK-1:0] ^ b_sh[CHUNK-1:0]) != p_sh[CHUNK-1:0]) ||
                       ((a_sh[CHUNK-1:0] & b_sh[CHUNK-1:0]) != g_sh[CHUNK-1:0]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            res_valid    <= 1'b0;
            res_pass     <= 1'b0;
            sum_err_mask <= '0;
            pg_err       <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            a_sh         <= '0;
            b_sh         <= '0;
            s_sh         <= '0;
            s_msb        <= 1'b0;
            mask_sh      <= '0;
            mask_msb     <= 1'b0;
            carry        <= 1'b0;
            pg_acc       <= 1'b0;
            k            <= '0;
`ifdef ADDER_CHECK_PG_EN
            p_sh         <= '0;
            g_sh         <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        s_sh     <= bus.S[WIDTH-1:0];
                        s_msb    <= bus.S[WIDTH];
                        carry    <= bus.Cin;
                        mask_sh  <= '0;
                        mask_msb <= 1'b0;
                        pg_acc   <= 1'b0;
                        k        <= '0;
`ifdef ADDER_CHECK_PG_EN
                        p_sh     <= bus.testP;
                        g_sh     <= bus.testG;
`endif
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    s_sh    <= s_sh >> CHUNK;
                    // New chunk enters at the top so the mask ends up in bit order after NCHUNK shifts.
                    mask_sh <= (mask_sh >> CHUNK) | (WIDTH'(chunk_diff) << (WIDTH - CHUNK));
                    carry   <= ref_sum[CHUNK];
                    pg_acc  <= pg_acc | chunk_pg_bad;
                    k       <= k + IDX_W'(1);
`ifdef ADDER_CHECK_PG_EN
                    p_sh    <= p_sh >> CHUNK;
                    g_sh    <= g_sh >> CHUNK;
`endif
                    if (k == LAST_IDX) begin
                        mask_msb <= ref_sum[CHUNK] ^ s_msb;
                        state    <= REPORT;
                    end
                end
                REPORT: begin
                    res_valid    <= 1'b1;
                    res_pass     <= (mask_sh == '0) && !mask_msb && !pg_acc;
                    sum_err_mask <= {mask_msb, mask_sh};
                    pg_err       <= pg_acc;
                    if ((mask_sh == '0) && !mask_msb && !pg_acc) begin
                        if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
                    end else begin
                        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
